// File: rtl/operand_entry.sv
// ---------------------------------------------------------------------------
// operand_entry
//
// Input-side front end for the calculator. Debounces the 'next' push-button,
// captures the switch word as operand A and then operand B, and presents the
// pair to the control FSM using a valid/ack handshake. While operands are
// being entered, entry_idx and din_live drive the seven-segment display.
//
// Parameters
//   WIDTH      operand / switch bus width
//   DB_CYCLES  consecutive samples that must disagree with the debounced
//              level before it changes (>= 2)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   clear      synchronous active-high reset
//   next       raw push-button, active-high
//   unary      1 = single-operand operation: B entry skipped, B forced to 0
//   Din        switch word
//   op_ack     FSM has consumed the operand pair
//   op_a/op_b  captured operands
//   op_valid   operand pair is stable and valid
//   entry_idx  0 = entering A, 1 = entering B, 2 = presenting
//   din_live   Din delayed by one cycle for the live display
//   press      one-cycle debounced press pulse
//
// Build option
//   INPUT_SYNC_EN  when defined, 'next' passes through a two-flop
//                  synchronizer before the debouncer (press latency +2).
//                  When undefined, 'next' is sampled directly.
// ---------------------------------------------------------------------------
module operand_entry #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             next,
  input  logic             unary,
  input  logic [WIDTH-1:0] Din,
  input  logic             op_ack,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  output logic [1:0]       entry_idx,
  output logic [WIDTH-1:0] din_live,
  output logic             press
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Button sample fed to the debouncer
  logic sample_s;

`ifdef INPUT_SYNC_EN
  logic sync1_q, sync2_q;
  logic sync1_d, sync2_d;

  always_comb begin
    sync1_d = next;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample_s = sync2_q;
`else
  assign sample_s = next;
`endif

  // Debounce and capture state
  logic             level_q,     level_d;
  logic             level_dly_q, level_dly_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             press_q,     press_d;
  logic [WIDTH-1:0] din_live_q,  din_live_d;
  logic [WIDTH-1:0] op_a_q,      op_a_d;
  logic [WIDTH-1:0] op_b_q,      op_b_d;
  logic             op_valid_q,  op_valid_d;
  state_t           state_q,     state_d;

  always_comb begin
    // Debouncer: any sample that agrees with the current level restarts the
    // count, so only an uninterrupted run of DB_CYCLES disagreeing samples
    // flips the level.
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sample_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sample_s;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // Rising-edge detect on the debounced level; the pulse appears the cycle
    // after the level rises, and a held button gives exactly one pulse.
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;

    din_live_d = Din;

    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    state_d    = state_q;

    unique case (state_q)
      ENTER_A: begin
        if (press_q) begin
          op_a_d = Din;
          if (unary) begin
            op_b_d     = '0;
            op_valid_d = 1'b1;
            state_d    = PRESENT;
          end else begin
            state_d = ENTER_B;
          end
        end
      end
      ENTER_B: begin
        if (press_q) begin
          op_b_d     = Din;
          op_valid_d = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        // Presses while presenting are dropped; the ack always wins.
        if (op_ack) begin
          op_valid_d = 1'b0;
          state_d    = ENTER_A;
        end
      end
      default: begin
        op_valid_d = 1'b0;
        state_d    = ENTER_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      din_live_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      state_q     <= ENTER_A;
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      din_live_q  <= din_live_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      state_q     <= state_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign entry_idx = state_q;
  assign din_live  = din_live_q;
  assign press     = press_q;

endmodule
